// File: rtl/seq_mant_mul_ctrl.sv
// Shift-and-add mantissa multiplier: one WIDTH+1-bit adder reused over WIDTH
// cycles, with a start/busy/done handshake and a held registered product.
module seq_mant_mul_ctrl #(
  parameter int WIDTH = 24,
  parameter int CW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  m;
  logic [WIDTH:0]    h;
  logic [WIDTH-1:0]  q;
  logic [CW-1:0]     cnt;
  logic [WIDTH:0]    sum;
  logic              accept;
  logic              last_step;

  // The only adder in the datapath; H never exceeds WIDTH bits before the add.
  assign sum       = h + (q[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
  assign accept    = (state == IDLE) && start;
  assign last_step = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m   <= '0;
      h   <= '0;
      q   <= '0;
      cnt <= '0;
      p   <= '0;
    end else if (accept) begin
      m   <= a;
      q   <= b;
      h   <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      // {H,Q} <= {S,Q} >> 1, zero entering the top of H
      h   <= {1'b0, sum[WIDTH:1]};
      q   <= {sum[0], q[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
      if (last_step) p <= {sum, q[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_seq_mant_mul_ctrl.sv
// Self-checking bench for seq_mant_mul_ctrl: directed table, multi-cycle corner
// sequences and a randomized regression against a plain a*b timing model.
module tb_seq_mant_mul_ctrl;

  localparam int W  = 24;
  localparam int CW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic              busy;
  logic              done;
  logic [2*W-1:0]    p;

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [2*W-1:0] model_p;

  seq_mant_mul_ctrl #(.WIDTH(W), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic [2*W-1:0] vp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // One multiplication: accept edge, WIDTH RUN steps, one DONE cycle, back to IDLE.
  // hold keeps start high with changing operands; inj>=0 pulses a spurious start.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                    input bit hold, input int inj);
    logic [2*W-1:0] exp;
    exp   = (2*W)'(x) * (2*W)'(y);
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int c = 0; c <= W; c++) begin
      if (c > 0) tick();
      chk("busy", 64'(busy), 64'd1);
      if (c < W) begin
        chk("done_early", 64'(done), 64'd0);
        chk("p_hold", 64'(p), 64'(model_p));
      end else begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("product", 64'(p), 64'(exp));
      end
      if (hold) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      if (c == inj) begin
        start = 1'b1;
        a = 24'h123456;
        b = 24'h654321;
      end else if (!hold && c == inj + 1) begin
        start = 1'b0;
      end
    end
    model_p = exp;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_p", 64'(p), 64'(model_p));
  endtask

  vec_t vecs[5];
  int   seen_done;
  logic [W-1:0] ra, rb;

  initial begin
    vecs[0] = '{24'h000001, 24'h000001, 48'h000000000001};
    vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    vecs[2] = '{24'h800000, 24'h800000, 48'h400000000000};
    vecs[3] = '{24'hC00000, 24'hC00000, 48'h900000000000};
    vecs[4] = '{24'h000000, 24'hABCDEF, 48'h000000000000};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    model_p = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_p", 64'(p), 64'd0);
    tick();
    chk("idle_no_start", 64'(busy), 64'd0);

    // Directed table, including table self-consistency with a*b
    for (int i = 0; i < 5; i++) begin
      chk("table_golden", 64'((2*W)'(vecs[i].va) * (2*W)'(vecs[i].vb)), 64'(vecs[i].vp));
      op(vecs[i].va, vecs[i].vb, 1'b0, -1);
      chk("table_p", 64'(p), 64'(vecs[i].vp));
    end

    // Spurious start mid-RUN is ignored
    op(24'h00ABCD, 24'h001234, 1'b0, 7);
    tick();
    chk("inject_no_restart", 64'(busy), 64'd0);
    chk("inject_p", 64'(p), 64'(48'h00ABCD * 48'h001234));

    // Reset on the 10th RUN cycle discards the operation
    a = 24'h333333; b = 24'h777777; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_run_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_p = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_p", 64'(p), 64'd0);
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || busy) seen_done++;
    end
    chk("abort_silent", 64'(seen_done), 64'd0);
    op(24'h333333, 24'h777777, 1'b0, -1);

    // Back-to-back with start held high: one acceptance per W+2 cycles
    for (int k = 0; k < 4; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      op(ra, rb, 1'b1, -1);
    end
    start = 1'b0;
    tick();
    chk("b2b_stop", 64'(busy), 64'd0);

    // Random regression with some boundary-biased operands
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: ra = '1;
        1: rb = '0;
        2: ra = W'(1) << $urandom_range(0, W-1);
        default: ;
      endcase
      op(ra, rb, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
